// File: rtl/systolic_wgt_loader.sv
// systolic_wgt_loader
//   Weight-load controller feeding the top PE row of a systolic array.
//   Accepts one weight tile as ARRAY_N row beats, shifts each row down the
//   vertical weight path, waits for the chain to settle, then (when the
//   compute side allows it) fires a one-cycle shadow-to-active swap.
//
//   Optional feature macro: WGT_LOADER_ZERO_PAD_EN
//     When defined, s_last marks the final beat of a short tile and the
//     loader pads the remaining rows with zero-data path-enable cycles.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   s_valid/s_ready/s_data   row-beat handshake, column c at [c*W +: W]
//   s_last         (macro only) final beat of a short tile
//   swap_allow     compute side permits the swap in this cycle
//   b_path_en_out  path enable into the top PE row
//   b_path_out     path data into the top PE row
//   b_en_out       shadow-to-active swap enable
//   busy           high whenever the FSM is not IDLE
//   tile_done      one-cycle pulse alongside b_en_out
module systolic_wgt_loader #(
    parameter int ARRAY_N        = 4,
    parameter int WGT_DATA_WIDTH = 8,
    parameter int SETTLE_CYCLES  = ARRAY_N
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [ARRAY_N*WGT_DATA_WIDTH-1:0]   s_data,
`ifdef WGT_LOADER_ZERO_PAD_EN
    input  logic                                s_last,
`endif
    input  logic                                swap_allow,
    output logic                                b_path_en_out,
    output logic [ARRAY_N*WGT_DATA_WIDTH-1:0]   b_path_out,
    output logic                                b_en_out,
    output logic                                busy,
    output logic                                tile_done
);

    localparam int DW    = ARRAY_N * WGT_DATA_WIDTH;
    localparam int CNT_W = $clog2(ARRAY_N + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(ARRAY_N - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
`ifdef WGT_LOADER_ZERO_PAD_EN
        PAD       = 3'd2,
`endif
        SETTLE    = 3'd3,
        WAIT_SWAP = 3'd4,
        SWAP      = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_nxt;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic              path_en_nxt;
    logic [DW-1:0]     path_nxt;
    logic              accept;

    // The handshake uses the registered s_ready, so a beat is only taken in
    // cycles where the upstream actually saw ready high.
    assign accept = s_valid && s_ready;

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat_cnt;
        settle_nxt  = settle_cnt;
        path_en_nxt = 1'b0;
        path_nxt    = b_path_out;

        case (state)
            IDLE: begin
                if (accept) begin
                    path_en_nxt = 1'b1;
                    path_nxt    = s_data;
                    beat_nxt    = CNT_W'(1);
                    state_nxt   = SHIFT;
`ifdef WGT_LOADER_ZERO_PAD_EN
                    // ARRAY_N >= 2, so beat 0 is always short when s_last is set.
                    if (s_last) state_nxt = PAD;
`endif
                end
            end
            SHIFT: begin
                if (accept) begin
                    path_en_nxt = 1'b1;
                    path_nxt    = s_data;
                    beat_nxt    = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt  = SETTLE;
                        settle_nxt = '0;
                    end
`ifdef WGT_LOADER_ZERO_PAD_EN
                    else if (s_last) begin
                        state_nxt = PAD;
                    end
`endif
                end
            end
`ifdef WGT_LOADER_ZERO_PAD_EN
            PAD: begin
                // Pads behave as zero-data beats so the real rows reach the bottom.
                path_en_nxt = 1'b1;
                path_nxt    = '0;
                beat_nxt    = beat_cnt + CNT_W'(1);
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
`endif
            SETTLE: begin
                if (settle_cnt == LAST_SETTLE) state_nxt = WAIT_SWAP;
                else settle_nxt = settle_cnt + SET_W'(1);
            end
            WAIT_SWAP: begin
                if (swap_allow) state_nxt = SWAP;
            end
            SWAP: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // All outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            settle_cnt    <= '0;
            s_ready       <= 1'b0;
            b_path_en_out <= 1'b0;
            b_path_out    <= '0;
            b_en_out      <= 1'b0;
            busy          <= 1'b0;
            tile_done     <= 1'b0;
        end else begin
            state         <= state_nxt;
            beat_cnt      <= beat_nxt;
            settle_cnt    <= settle_nxt;
            s_ready       <= (state_nxt == IDLE) || (state_nxt == SHIFT);
            b_path_en_out <= path_en_nxt;
            b_path_out    <= path_nxt;
            b_en_out      <= (state_nxt == SWAP);
            busy          <= (state_nxt != IDLE);
            tile_done     <= (state_nxt == SWAP);
        end
    end

endmodule

// File: tb/tb_systolic_wgt_loader.sv
// tb_systolic_wgt_loader
//   Scoreboard bench for systolic_wgt_loader (ARRAY_N=4, 8-bit weights,
//   SETTLE_CYCLES=4). Expected path beats are queued with their expected
//   output cycle when the stimulus is accepted; a negedge monitor pops and
//   compares them. Scenario tasks check swap timing and reset behaviour.
module tb_systolic_wgt_loader;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int S  = 4;
    localparam int DW = N * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
`ifdef WGT_LOADER_ZERO_PAD_EN
    logic          s_last = 1'b0;
`endif
    logic          swap_allow = 1'b0;
    logic          b_path_en_out;
    logic [DW-1:0] b_path_out;
    logic          b_en_out;
    logic          busy;
    logic          tile_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_q = 1'b0;
    logic [DW-1:0] model_path = '0;
    int path_pulses = 0;
    int done_cnt = 0;

    logic [DW-1:0] exp_data[$];
    int            exp_cyc[$];

    systolic_wgt_loader #(
        .ARRAY_N(N),
        .WGT_DATA_WIDTH(W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
`ifdef WGT_LOADER_ZERO_PAD_EN
        .s_last(s_last),
`endif
        .swap_allow(swap_allow),
        .b_path_en_out(b_path_en_out),
        .b_path_out(b_path_out),
        .b_en_out(b_en_out),
        .busy(busy),
        .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst_q) begin
            exp_data.delete();
            exp_cyc.delete();
            model_path = '0;
            checks++;
            if (s_ready !== 1'b0 || b_path_en_out !== 1'b0 || b_path_out !== '0 ||
                b_en_out !== 1'b0 || busy !== 1'b0 || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b pen=%b path=%h en=%b busy=%b done=%b, required all 0",
                         s_ready, b_path_en_out, b_path_out, b_en_out, busy, tile_done);
            end
        end else begin
            checks++;
            if (b_path_en_out === 1'b1) begin
                path_pulses++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("FAIL path_unexpected: enable at cycle %0d data %h, required no enable", cyc, b_path_out);
                end else begin
                    logic [DW-1:0] d;
                    int c;
                    d = exp_data.pop_front();
                    c = exp_cyc.pop_front();
                    model_path = d;
                    if (b_path_out !== d || cyc != c) begin
                        errors++;
                        $display("FAIL path_beat: data %h at cycle %0d, required %h at cycle %0d",
                                 b_path_out, cyc, d, c);
                    end
                end
            end else if (b_path_out !== model_path) begin
                errors++;
                $display("FAIL path_hold: path %h with enable low, required %h", b_path_out, model_path);
            end
            checks++;
            if (b_en_out !== tile_done) begin
                errors++;
                $display("FAIL swap_done_match: b_en_out=%b tile_done=%b, required equal", b_en_out, tile_done);
            end
            if (tile_done === 1'b1) done_cnt++;
        end
    end

    task automatic drive_beat(input logic [DW-1:0] d, input logic last, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        s_valid = 1'b1;
        s_data  = d;
`ifdef WGT_LOADER_ZERO_PAD_EN
        s_last  = last;
`else
        if (last) $display("note: s_last requested without pad support");
`endif
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok  = 1'b1;
                acc = cyc;
                exp_data.push_back(d);
                exp_cyc.push_back(cyc + 1);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
`ifdef WGT_LOADER_ZERO_PAD_EN
        s_last  = 1'b0;
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: s_ready stayed low for 64 cycles, required 1");
        end
    endtask

    // Waits (bounded) for b_en_out; reports its cycle (-1 on timeout) and
    // whether s_ready was seen high before it.
    task automatic wait_en(input int budget, output int at, output bit rdy_seen);
        at = -1;
        rdy_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (b_en_out === 1'b1) begin
                at = cyc;
                break;
            end
            if (s_ready === 1'b1) rdy_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: s_ready=%b in reset cycle, required 0", s_ready);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: s_ready=%b busy=%b after reset, required 1/0", s_ready, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_tile();
        int L, at, p0;
        bit rdy;
        swap_allow = 1'b1;
        p0 = path_pulses;
        for (int i = 0; i < N; i++) drive_beat(DW'($urandom()), 1'b0, L);
        wait_en(100, at, rdy);
        checks++;
        if (at != L + S + 2 || rdy) begin
            errors++;
            $display("FAIL full_swap_time: b_en_out at %0d ready_seen=%b, required %0d/0", at, rdy, L + S + 2);
        end
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_swap_state: busy=%b s_ready=%b in SWAP, required 1/0", busy, s_ready);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || b_en_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_after_swap: ready=%b en=%b busy=%b, required 1/0/0", s_ready, b_en_out, busy);
        end
        checks++;
        if (path_pulses - p0 != N) begin
            errors++;
            $display("FAIL full_pulses: %0d path enables, required %0d", path_pulses - p0, N);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bubbles();
        int L, at, p0;
        bit rdy;
        swap_allow = 1'b1;
        p0 = path_pulses;
        for (int i = 0; i < N; i++) begin
            drive_beat(DW'($urandom()), 1'b0, L);
            if (i != N - 1) repeat (2) @(posedge clk);
            #1;
        end
        wait_en(100, at, rdy);
        checks++;
        if (at != L + S + 2) begin
            errors++;
            $display("FAIL bubble_swap_time: b_en_out at %0d, required %0d", at, L + S + 2);
        end
        checks++;
        if (path_pulses - p0 != N) begin
            errors++;
            $display("FAIL bubble_pulses: %0d path enables, required %0d", path_pulses - p0, N);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_swap_hold();
        int L, at, w;
        bit rdy, bad;
        swap_allow = 1'b0;
        for (int i = 0; i < N; i++) drive_beat(DW'($urandom()), 1'b0, L);
        bad = 1'b0;
        // WAIT_SWAP starts at L+S+1; keep swap_allow low for 10 of its cycles.
        while (cyc < L + S + 11) begin
            @(negedge clk);
            if (b_en_out !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_wait: swap or ready seen while swap_allow low, required en=0 ready=0 busy=1");
        end
        swap_allow = 1'b1;
        w = cyc;
        wait_en(50, at, rdy);
        checks++;
        if (at != w + 1 || rdy) begin
            errors++;
            $display("FAIL hold_swap_time: b_en_out at %0d ready_seen=%b, required %0d/0", at, rdy, w + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int L, d0;
        bit bad;
        swap_allow = 1'b1;
        d0 = done_cnt;
        drive_beat(DW'($urandom()), 1'b0, L);
        drive_beat(DW'($urandom()), 1'b0, L);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (s_ready !== 1'b0 || b_path_en_out !== 1'b0 || b_path_out !== '0 ||
            b_en_out !== 1'b0 || busy !== 1'b0 || tile_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready=%b pen=%b path=%h en=%b busy=%b done=%b, required all 0",
                     s_ready, b_path_en_out, b_path_out, b_en_out, busy, tile_done);
        end
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (b_en_out !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || done_cnt != d0) begin
            errors++;
            $display("FAIL mid_reset_no_swap: swap/busy seen after reset (done delta %0d), required none", done_cnt - d0);
        end
        @(posedge clk);
        #1;
        test_full_tile();
    endtask

    task automatic test_back_to_back();
        int L, L1, F2, at, d0;
        bit rdy;
        swap_allow = 1'b1;
        d0 = done_cnt;
        L1 = -1;
        F2 = -1;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) begin
                drive_beat(DW'($urandom()), 1'b0, L);
                if (t == 0 && i == N - 1) L1 = L;
                if (t == 1 && i == 0) F2 = L;
                s_valid = 1'b1;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (F2 != L1 + S + 3) begin
            errors++;
            $display("FAIL b2b_gap: second tile first beat at %0d, required %0d", F2, L1 + S + 3);
        end
        wait_en(100, at, rdy);
        checks++;
        if (at != L + S + 2) begin
            errors++;
            $display("FAIL b2b_swap_time: b_en_out at %0d, required %0d", at, L + S + 2);
        end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_done_count: %0d tile_done pulses, required 2", done_cnt - d0);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef WGT_LOADER_ZERO_PAD_EN
    task automatic test_zero_pad();
        int L, at;
        bit rdy;
        swap_allow = 1'b1;
        drive_beat(DW'($urandom()), 1'b0, L);
        drive_beat(DW'($urandom()), 1'b1, L);
        exp_data.push_back('0);
        exp_cyc.push_back(L + 2);
        exp_data.push_back('0);
        exp_cyc.push_back(L + 3);
        // PAD occupies L+1..L+2; the swap follows the last pad cycle by S+2.
        wait_en(100, at, rdy);
        checks++;
        if (at != L + 2 + S + 2 || rdy) begin
            errors++;
            $display("FAIL pad_swap_time: b_en_out at %0d ready_seen=%b, required %0d/0", at, rdy, L + S + 4);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_full_tile();
        test_bubbles();
        test_swap_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef WGT_LOADER_ZERO_PAD_EN
        test_zero_pad();
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_data.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected beats never seen, required 0", exp_data.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
